// File: rtl/polyphase_tx_shaper_if.sv
// Symbol-in / shaped-sample-out signal bundle for polyphase_tx_shaper.
// The driver of symbols and strobes uses master; the shaper uses slave.
interface polyphase_tx_shaper_if #(
  parameter int OSF = 20,
  parameter int WIQ = 16,
  parameter int WO  = 18
);
  localparam int PW = (OSF > 1) ? $clog2(OSF) : 1;

  logic signed [WIQ-1:0] i_sym_i;
  logic signed [WIQ-1:0] q_sym_i;
  logic                  sym_valid_i;
  logic                  sym_ready_o;
  logic                  sample_en_i;
  logic signed [WO-1:0]  i_o;
  logic signed [WO-1:0]  q_o;
  logic                  iq_val_o;
  logic [PW-1:0]         phase_o;
  logic                  underrun_o;

  modport master (
    output i_sym_i, q_sym_i, sym_valid_i, sample_en_i,
    input  sym_ready_o, i_o, q_o, iq_val_o, phase_o, underrun_o
  );

  modport slave (
    input  i_sym_i, q_sym_i, sym_valid_i, sample_en_i,
    output sym_ready_o, i_o, q_o, iq_val_o, phase_o, underrun_o
  );
endinterface

// File: rtl/polyphase_tx_shaper.sv
// Polyphase transmit pulse shaper: one-entry symbol hold, TAPS_PPH-deep symbol
// line, OSF-branch half-sine coefficient ROM, one saturated I/Q sample per strobe.
module polyphase_tx_shaper #(
  parameter int OSF      = 20,
  parameter int TAPS_PPH = 5,
  parameter int WIQ      = 16,
  parameter int WO       = 18
) (
  input logic            clk,
  input logic            reset,
  polyphase_tx_shaper_if.slave sif
);
  localparam int PW   = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int TW   = (TAPS_PPH > 1) ? $clog2(TAPS_PPH) : 1;
  localparam int WACC = WIQ + 16 + TW + 1;

  localparam longint ONE   = 64'sd1 << 30;
  localparam longint PI_FX = 64'sd3373259426;

  localparam logic signed [WACC-1:0] MAX_O = WACC'((64'sd1 <<< (WO - 1)) - 64'sd1);
  localparam logic signed [WACC-1:0] MIN_O = -MAX_O - WACC'(1);

  // Fixed-point Taylor sine (argument folded into [0, pi/2]) so the ROM is
  // built at elaboration without real arithmetic.
  function automatic logic signed [15:0] coef_f(input int p);
    longint x;
    longint term;
    longint s;
    x = (PI_FX * longint'(2 * p + 1)) / longint'(2 * OSF);
    if (x > PI_FX / 2) x = PI_FX - x;
    term = x;
    s    = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) / ONE;
      term = (term * x) / ONE;
      term = -term / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return 16'((s * 64'sd32767) / (ONE * longint'(TAPS_PPH)));
  endfunction

  function automatic logic signed [WO-1:0] sat_f(input logic signed [WACC-1:0] a);
    logic signed [WACC-1:0] s;
    s = a >>> 15;
    if (s > MAX_O) s = MAX_O;
    else if (s < MIN_O) s = MIN_O;
    return s[WO-1:0];
  endfunction

  logic signed [15:0] coef_rom [OSF];

  for (genvar gp = 0; gp < OSF; gp++) begin : g_rom
    localparam logic signed [15:0] C = coef_f(gp);
    assign coef_rom[gp] = C;
  end

  logic [PW-1:0]         phase_q;
  logic                  hold_full;
  logic signed [WIQ-1:0] hold_i;
  logic signed [WIQ-1:0] hold_q;
  logic signed [WIQ-1:0] d_i  [TAPS_PPH];
  logic signed [WIQ-1:0] d_q  [TAPS_PPH];
  logic signed [WIQ-1:0] dn_i [TAPS_PPH];
  logic signed [WIQ-1:0] dn_q [TAPS_PPH];

  logic                  sym_ready_q;
  logic signed [WO-1:0]  i_q;
  logic signed [WO-1:0]  q_q;
  logic                  val_q;
  logic [PW-1:0]         phase_out_q;
  logic                  underrun_q;

  logic                  accept;
  logic                  ph0_strobe;
  logic                  consume;
  logic                  hold_full_nxt;
  logic signed [15:0]    coef_sel;
  logic signed [WACC-1:0] acc_i;
  logic signed [WACC-1:0] acc_q;

  assign accept        = sif.sym_valid_i & sym_ready_q;
  assign ph0_strobe    = sif.sample_en_i & (phase_q == '0);
  assign consume       = ph0_strobe & hold_full;
  // Consume sees only the registered hold; a same-cycle accept refills it.
  assign hold_full_nxt = accept | (hold_full & ~consume);
  assign coef_sel      = coef_rom[phase_q];

  always_comb begin
    for (int k = 0; k < TAPS_PPH; k++) begin
      dn_i[k] = d_i[k];
      dn_q[k] = d_q[k];
    end
    if (ph0_strobe) begin
      dn_i[0] = hold_full ? hold_i : '0;
      dn_q[0] = hold_full ? hold_q : '0;
      for (int k = 1; k < TAPS_PPH; k++) begin
        dn_i[k] = d_i[k-1];
        dn_q[k] = d_q[k-1];
      end
    end
  end

  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int k = 0; k < TAPS_PPH; k++) begin
      acc_i = acc_i + WACC'(dn_i[k]) * WACC'(coef_sel);
      acc_q = acc_q + WACC'(dn_q[k]) * WACC'(coef_sel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= '0;
      hold_full   <= 1'b0;
      hold_i      <= '0;
      hold_q      <= '0;
      sym_ready_q <= 1'b0;
      for (int k = 0; k < TAPS_PPH; k++) begin
        d_i[k] <= '0;
        d_q[k] <= '0;
      end
      i_q         <= '0;
      q_q         <= '0;
      val_q       <= 1'b0;
      phase_out_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full   <= hold_full_nxt;
      sym_ready_q <= ~hold_full_nxt;
      if (accept) begin
        hold_i <= sif.i_sym_i;
        hold_q <= sif.q_sym_i;
      end
      if (sif.sample_en_i) begin
        phase_q <= (phase_q == PW'(OSF - 1)) ? '0 : phase_q + PW'(1);
        for (int k = 0; k < TAPS_PPH; k++) begin
          d_i[k] <= dn_i[k];
          d_q[k] <= dn_q[k];
        end
        i_q         <= sat_f(acc_i);
        q_q         <= sat_f(acc_q);
        phase_out_q <= phase_q;
      end
      val_q      <= sif.sample_en_i;
      underrun_q <= ph0_strobe & ~hold_full;
    end
  end

  assign sif.sym_ready_o = sym_ready_q;
  assign sif.i_o         = i_q;
  assign sif.q_o         = q_q;
  assign sif.iq_val_o    = val_q;
  assign sif.phase_o     = phase_out_q;
  assign sif.underrun_o  = underrun_q;
endmodule
